// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: core port C has priority,
// loader port L is starvation-protected, read data returns registered one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              C_REQ,
  input  logic              C_WE,
  input  logic [ADDR_W-1:0] C_A,
  input  logic [DATA_W-1:0] C_WD,
  output logic              C_GNT,
  output logic              C_RVALID,
  output logic [DATA_W-1:0] C_RD,
  input  logic              L_REQ,
  input  logic              L_WE,
  input  logic [ADDR_W-1:0] L_A,
  input  logic [DATA_W-1:0] L_WD,
  output logic              L_GNT,
  output logic              L_RVALID,
  output logic [DATA_W-1:0] L_RD,
  output logic [ADDR_W-1:0] M_A,
  output logic [DATA_W-1:0] M_WD,
  output logic              M_WE,
  input  logic [DATA_W-1:0] M_RD
);

  typedef enum logic [1:0] {RESP_NONE, RESP_C, RESP_L} resp_t;

  resp_t      resp_state;
  logic [3:0] wait_cnt;
  logic       force_l;
  logic       c_rd_gnt;
  logic       l_rd_gnt;

  // Grant stage: combinational arbitration, both grants held low during reset
  assign force_l  = (wait_cnt == 4'(MAX_WAIT));
  assign C_GNT    = RST_N & C_REQ & ~(L_REQ & force_l);
  assign L_GNT    = RST_N & L_REQ & (~C_REQ | force_l);
  assign c_rd_gnt = C_GNT & ~C_WE;
  assign l_rd_gnt = L_GNT & ~L_WE;

  assign M_A  = L_GNT ? L_A  : C_A;
  assign M_WD = L_GNT ? L_WD : C_WD;
  assign M_WE = (C_GNT & C_WE) | (L_GNT & L_WE);

  // Response stage: capture read data and remember which port owns it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_state <= RESP_NONE;
      wait_cnt   <= 4'd0;
      C_RD       <= '0;
      L_RD       <= '0;
    end else begin
      if (c_rd_gnt) begin
        resp_state <= RESP_C;
        C_RD       <= M_RD;
      end else if (l_rd_gnt) begin
        resp_state <= RESP_L;
        L_RD       <= M_RD;
      end else begin
        resp_state <= RESP_NONE;
      end

      if (L_GNT)
        wait_cnt <= 4'd0;
      else if (L_REQ && !force_l)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign C_RVALID = (resp_state == RESP_C);
  assign L_RVALID = (resp_state == RESP_L);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked against
// a rule-level model of grants, memory contents and read responses.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              C_REQ = 1'b0, C_WE = 1'b0, L_REQ = 1'b0, L_WE = 1'b0;
  logic [ADDR_W-1:0] C_A = '0, L_A = '0;
  logic [DATA_W-1:0] C_WD = '0, L_WD = '0;
  logic              C_GNT, C_RVALID, L_GNT, L_RVALID, M_WE;
  logic [DATA_W-1:0] C_RD, L_RD, M_WD, M_RD;
  logic [ADDR_W-1:0] M_A;

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_A(C_A), .C_WD(C_WD),
    .C_GNT(C_GNT), .C_RVALID(C_RVALID), .C_RD(C_RD),
    .L_REQ(L_REQ), .L_WE(L_WE), .L_A(L_A), .L_WD(L_WD),
    .L_GNT(L_GNT), .L_RVALID(L_RVALID), .L_RD(L_RD),
    .M_A(M_A), .M_WD(M_WD), .M_WE(M_WE), .M_RD(M_RD)
  );

  always #5 CLK = ~CLK;

  // Stand-in for data_memory: combinational read, write on rising edge
  logic [DATA_W-1:0] dmem [16];
  assign M_RD = dmem[M_A[3:0]];
  always @(posedge CLK) if (M_WE) dmem[M_A[3:0]] <= M_WD;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [16];
  int                streak;
  logic              exp_cv, exp_lv;
  logic [DATA_W-1:0] exp_crd, exp_lrd;

  function automatic logic model_lgnt();
    return RST_N && L_REQ && (!C_REQ || streak == MAX_WAIT);
  endfunction

  function automatic logic model_cgnt();
    return RST_N && C_REQ && !model_lgnt();
  endfunction

  task automatic model_reset();
    exp_cv = 1'b0; exp_lv = 1'b0; exp_crd = '0; exp_lrd = '0; streak = 0;
  endtask

  task automatic edge_step();
    logic gc, gl;
    gc = model_cgnt();
    gl = model_lgnt();
    @(posedge CLK);
    exp_cv = gc && !C_WE;
    exp_lv = gl && !L_WE;
    if (exp_cv) exp_crd = ref_mem[C_A[3:0]];
    if (exp_lv) exp_lrd = ref_mem[L_A[3:0]];
    if (gc && C_WE) ref_mem[C_A[3:0]] = C_WD;
    if (gl && L_WE) ref_mem[L_A[3:0]] = L_WD;
    if (!RST_N || gl) streak = 0;
    else if (L_REQ && streak < MAX_WAIT) streak++;
    #1;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [3:0] ca, input logic [31:0] cwd,
                       input logic lreq, input logic lwe, input logic [3:0] la, input logic [31:0] lwd);
    C_REQ = creq; C_WE = cwe; C_A = {28'd0, ca}; C_WD = cwd;
    L_REQ = lreq; L_WE = lwe; L_A = {28'd0, la}; L_WD = lwd;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    RST_N = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'd0);
    vectors++;
    if ({M_WE, C_GNT, L_GNT, C_RVALID, L_RVALID} !== 5'b0 || C_RD !== '0 || L_RD !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: we/cg/lg/cv/lv=%b crd=%h lrd=%h, required all zero",
               {M_WE, C_GNT, L_GNT, C_RVALID, L_RVALID}, C_RD, L_RD);
    end
    edge_step();
    edge_step();
    vectors++;
    if (M_WE !== 1'b0 || C_RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: M_WE=%b C_RVALID=%b, required 0 0", M_WE, C_RVALID);
    end
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    RST_N = 1'b1;
    drive(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    edge_step();
    vectors++;
    if (C_RVALID !== 1'b1 || C_RD !== 32'h1000_0000) begin
      miscompares++;
      $display("FAIL reset_no_write: C_RVALID=%b C_RD=%h, required 1 10000000", C_RVALID, C_RD);
    end
  endtask

  task automatic test_core_rw();
    drive(1'b1, 1'b1, 4'd0, 32'h12345678, 1'b0, 1'b0, 4'd0, 32'd0);
    vectors++;
    if (C_GNT !== 1'b1 || M_WE !== 1'b1) begin
      miscompares++;
      $display("FAIL core_write_gnt: C_GNT=%b M_WE=%b, required 1 1", C_GNT, M_WE);
    end
    edge_step();
    vectors++;
    if (C_RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL core_write_novalid: C_RVALID=%b, required 0", C_RVALID);
    end
    drive(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    vectors++;
    if (C_GNT !== 1'b1 || M_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL core_read_gnt: C_GNT=%b M_WE=%b, required 1 0", C_GNT, M_WE);
    end
    edge_step();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    vectors++;
    if (C_RVALID !== 1'b1 || C_RD !== 32'h12345678) begin
      miscompares++;
      $display("FAIL core_read_data: C_RVALID=%b C_RD=%h, required 1 12345678", C_RVALID, C_RD);
    end
    edge_step();
    vectors++;
    if (C_RVALID !== 1'b0 || C_RD !== 32'h12345678) begin
      miscompares++;
      $display("FAIL core_read_hold: C_RVALID=%b C_RD=%h, required 0 12345678", C_RVALID, C_RD);
    end
  endtask

  task automatic test_loader_alone();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd1, 32'h87654321);
    vectors++;
    if (L_GNT !== 1'b1 || C_GNT !== 1'b0 || M_WE !== 1'b1 || M_A !== 32'd1) begin
      miscompares++;
      $display("FAIL loader_write_gnt: L_GNT=%b C_GNT=%b M_WE=%b M_A=%h, required 1 0 1 1",
               L_GNT, C_GNT, M_WE, M_A);
    end
    edge_step();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd1, 32'd0);
    edge_step();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    vectors++;
    if (L_RVALID !== 1'b1 || L_RD !== 32'h87654321 || C_RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL loader_read: L_RVALID=%b L_RD=%h C_RVALID=%b, required 1 87654321 0",
               L_RVALID, L_RD, C_RVALID);
    end
  endtask

  task automatic test_contention();
    logic exp_l;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    RST_N = 1'b0;
    model_reset();
    #2;
    RST_N = 1'b1;
    drive(1'b1, 1'b0, 4'd3, 32'd0, 1'b1, 1'b0, 4'd4, 32'd0);
    for (int k = 0; k < 11; k++) begin
      exp_l = (k % 5 == 4);
      vectors++;
      if (C_GNT !== !exp_l || L_GNT !== exp_l) begin
        miscompares++;
        $display("FAIL contention_c%0d: C_GNT=%b L_GNT=%b, required %b %b", k, C_GNT, L_GNT, !exp_l, exp_l);
      end
      edge_step();
      vectors++;
      if (C_RVALID !== !exp_l || L_RVALID !== exp_l || (!exp_l && C_RD !== ref_mem[3]) ||
          (exp_l && L_RD !== ref_mem[4])) begin
        miscompares++;
        $display("FAIL contention_resp%0d: cv=%b lv=%b crd=%h lrd=%h, required %b %b %h %h",
                 k, C_RVALID, L_RVALID, C_RD, L_RD, !exp_l, exp_l, ref_mem[3], ref_mem[4]);
      end
    end
  endtask

  task automatic test_hazard();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd2, 32'hCAFEF00D);
    edge_step();
    drive(1'b1, 1'b0, 4'd2, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    edge_step();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    vectors++;
    if (C_RVALID !== 1'b1 || C_RD !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL hazard: C_RVALID=%b C_RD=%h, required 1 cafef00d", C_RVALID, C_RD);
    end
  endtask

  task automatic test_midop_reset();
    drive(1'b1, 1'b0, 4'd5, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    vectors++;
    if (C_GNT !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_gnt: C_GNT=%b, required 1", C_GNT);
    end
    RST_N = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (C_GNT !== 1'b0 || C_RD !== '0 || C_RVALID !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_async: C_GNT=%b C_RD=%h C_RVALID=%b, required 0 0 0", C_GNT, C_RD, C_RVALID);
    end
    edge_step();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    RST_N = 1'b1;
    for (int k = 0; k < 2; k++) begin
      edge_step();
      vectors++;
      if (C_RVALID !== 1'b0 || L_RVALID !== 1'b0 || C_RD !== '0) begin
        miscompares++;
        $display("FAIL midop_after%0d: C_RVALID=%b L_RVALID=%b C_RD=%h, required 0 0 0",
                 k, C_RVALID, L_RVALID, C_RD);
      end
    end
  endtask

  task automatic test_random();
    logic c_pend, l_pend, gc, gl;
    logic [ADDR_W-1:0] ea;
    c_pend = 1'b0; l_pend = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!c_pend) begin
        C_REQ = ($urandom_range(0, 9) < 6); C_WE = $urandom_range(0, 1);
        C_A = ADDR_W'($urandom_range(0, 7)); C_WD = $urandom;
      end
      if (!l_pend) begin
        L_REQ = ($urandom_range(0, 9) < 7); L_WE = $urandom_range(0, 1);
        L_A = ADDR_W'($urandom_range(0, 7)); L_WD = $urandom;
      end
      #1;
      gc = model_cgnt(); gl = model_lgnt();
      ea = gl ? L_A : C_A;
      vectors++;
      if (C_GNT !== gc || L_GNT !== gl || M_WE !== ((gc && C_WE) || (gl && L_WE)) ||
          ((gc || gl) && (M_A !== ea || M_WD !== (gl ? L_WD : C_WD)))) begin
        miscompares++;
        $display("FAIL rand_grant%0d: cg=%b lg=%b we=%b a=%h, required %b %b %b %h",
                 k, C_GNT, L_GNT, M_WE, M_A, gc, gl, (gc && C_WE) || (gl && L_WE), ea);
      end
      edge_step();
      c_pend = C_REQ && !gc;
      l_pend = L_REQ && !gl;
      vectors++;
      if (C_RVALID !== exp_cv || L_RVALID !== exp_lv || C_RD !== exp_crd || L_RD !== exp_lrd) begin
        miscompares++;
        $display("FAIL rand_resp%0d: cv=%b lv=%b crd=%h lrd=%h, required %b %b %h %h",
                 k, C_RVALID, L_RVALID, C_RD, L_RD, exp_cv, exp_lv, exp_crd, exp_lrd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      dmem[i]    = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    model_reset();
    #2;
    test_reset();
    test_core_rw();
    test_loader_alone();
    test_contention();
    test_hazard();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port `data_memory`.
- `data_memory` behaviour: combinational read of RD from A; write of WD at A on the rising CLK edge when WE=1.
- Shares the memory between the core load/store unit (port C, high priority) and the program/debug loader (port L, low priority, starvation-protected).
- Returns registered read data with a per-port valid strobe one cycle after grant.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory side.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced ahead of the core (range 1..15).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- C_REQ  in  1  core request valid.
- C_WE  in  1  core write (1) / read (0).
- C_A  in  ADDR_W  core address.
- C_WD  in  DATA_W  core write data.
- C_GNT  out  1  core request accepted this cycle (combinational).
- C_RVALID  out  1  core read data valid (registered, one-cycle pulse).
- C_RD  out  DATA_W  core read data (registered, holds until the next core read completes).
- L_REQ, L_WE, L_A, L_WD  in  1/1/ADDR_W/DATA_W  loader request; same meaning as the core fields.
- L_GNT  out  1  loader accepted this cycle (combinational).
- L_RVALID  out  1  loader read data valid (registered pulse).
- L_RD  out  DATA_W  loader read data (registered, held).
- M_A  out  ADDR_W  to `data_memory` A.
- M_WD  out  DATA_W  to `data_memory` WD.
- M_WE  out  1  to `data_memory` WE.
- M_RD  in  DATA_W  from `data_memory` RD.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - C_RVALID, L_RVALID, C_RD, L_RD, wait counter, force flag all 0.
  - C_GNT, L_GNT, M_WE forced to 0 while RST_N=0, so no write occurs in a reset cycle.
  - Reset asserted mid-transaction drops any pending read response; no RVALID appears after release.
- Arbitration (combinational, each cycle):
  - `force` = (wait_cnt == MAX_WAIT).
  - Only one requester: that requester is granted.
  - Both requesting, `force`=0: C granted.
  - Both requesting, `force`=1: L granted.
  - Exactly one GNT or none per cycle; never both.
- Memory drive:
  - M_A and M_WD come from the granted port; C's fields when idle.
  - M_WE = granted port's WE & GNT.
  - A write commits at the edge ending the grant cycle.
- Read response:
  - On a granted read, M_RD is captured into that port's RD register at the edge ending the grant cycle.
  - The port's RVALID is 1 for exactly the following cycle, so latency = 1 cycle.
  - A granted write produces no RVALID.
  - Back-to-back reads on one port give one RVALID per grant, every cycle.
- Starvation counter wait_cnt (4 bits):
  - +1 each edge where L_REQ=1 and L_GNT=0; saturates at MAX_WAIT.
  - Clears to 0 on any L grant.
  - Holds when L_REQ=0.
- Response routing uses a 3-state FSM registered at each edge: RESP_NONE, RESP_C, RESP_L.
  - Next state RESP_C if C was granted a read, RESP_L if L was granted a read, else RESP_NONE.
  - RVALIDs decode from the state.
- Hazard: a write in cycle N followed by a read of the same address in cycle N+1, from either port, returns the new data.
- Requesters hold REQ/WE/A/WD stable until GNT. The arbiter does not queue requests.

Test Plan:
1. Reset: RST_N=0 with C_REQ=1, C_WE=1, C_WD=32'hDEADBEEF, A=0 → M_WE=0, all outputs 0. After release, C read of A=0 → C_RD equals the pre-reset memory content, not DEADBEEF.
2. Core write/read: C writes 32'h12345678 to A=0, then reads A=0 → C_GNT=1 both cycles, C_RVALID=1 exactly one cycle after the read grant, C_RD=32'h12345678.
3. Loader alone: L writes 32'h87654321 to A=1, then reads A=1 → L_RD=32'h87654321 with L_RVALID one cycle after grant; C_RVALID stays 0.
4. Contention, MAX_WAIT=4: C_REQ and L_REQ held high continuously → C granted cycles 0–3, L granted cycle 4, wait_cnt back to 0, then C granted again.
5. Hazard: L writes 32'hCAFEF00D to A=2, C reads A=2 the next cycle → C_RD=32'hCAFEF00D.
6. Mid-op reset: C read granted, RST_N pulsed low before the next edge → C_RVALID never asserts; FSM in RESP_NONE after release.
